// File: rtl/half_adder_unit.sv
// half_adder_unit: WIDTH independent half-adder lanes.
// The combinational sum/cout outputs are available with zero latency, and a
// one-stage registered copy carries a valid flag. A saturating counter records
// how many accepted cycles produced a carry in at least one lane.
// Bitwise operators keep lanes isolated, so an X/Z on one lane stays on that
// lane. No backpressure: a new operand pair can be accepted every cycle.
module half_adder_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] cout_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  // Increment that sticks at the all-ones value instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_W'(1);
    return r;
  endfunction

  // ---- stage p0: combinational half-adder lanes ----
  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH-1:0] cout_p0;
  logic             vld_p0;
  logic             any_carry_p0;

  assign sum_p0       = a ^ b;
  assign cout_p0      = a & b;
  assign vld_p0       = in_valid;
  assign any_carry_p0 = |cout_p0;

  assign sum  = sum_p0;
  assign cout = cout_p0;

  // ---- stage p1: registered result, valid flag and carry-event counter ----
  logic [WIDTH-1:0] sum_p1_d,  sum_p1_q;
  logic [WIDTH-1:0] cout_p1_d, cout_p1_q;
  logic             vld_p1_d,  vld_p1_q;
  logic [CNT_W-1:0] cnt_d,     cnt_q;

  // Next-state: capture on valid, otherwise hold data; clear beats increment.
  always_comb begin
    sum_p1_d  = sum_p1_q;
    cout_p1_d = cout_p1_q;
    vld_p1_d  = vld_p0;
    cnt_d     = cnt_q;
    if (vld_p0) begin
      sum_p1_d  = sum_p0;
      cout_p1_d = cout_p0;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (vld_p0 && any_carry_p0) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // State registers; asynchronous reset clears results, valid and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1_q  <= '0;
      cout_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sum_p1_q  <= sum_p1_d;
      cout_p1_q <= cout_p1_d;
      vld_p1_q  <= vld_p1_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sum_q     = sum_p1_q;
  assign cout_q    = cout_p1_q;
  assign out_valid = vld_p1_q;
  assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder_unit.sv
// Bench for half_adder_unit: a WIDTH=1/CNT_W=16 instance and a
// WIDTH=4/CNT_W=2 instance. Expected registered results are queued at issue
// time and popped by a monitor whenever out_valid is seen.
module tb_half_adder_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a1, b1, v1, clr1;
  logic [3:0]  a4, b4;
  logic        v4, clr4;

  logic        sum1, cout1, sq1, cq1, ov1;
  logic [15:0] cnt1;
  logic [3:0]  sum4, cout4, sq4, cq4;
  logic        ov4;
  logic [1:0]  cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q1[$];
  logic [7:0] q4[$];
  logic [1:0] e1;
  logic [7:0] e4;

  // reference model state
  logic        hs1, hc1;
  logic [15:0] cnt1_m;
  logic [3:0]  hs4, hc4;
  logic [1:0]  cnt4_m;

  always #5 clk = ~clk;

  half_adder_unit #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .cnt_clr(clr1),
    .sum(sum1), .cout(cout1), .sum_q(sq1), .cout_q(cq1), .out_valid(ov1),
    .carry_cnt(cnt1)
  );

  half_adder_unit #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4), .cnt_clr(clr4),
    .sum(sum4), .cout(cout4), .sum_q(sq4), .cout_q(cq4), .out_valid(ov4),
    .carry_cnt(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov1 === 1'b1) begin
      if (q1.size() == 0) chk("sb1_unexpected_valid", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("sb1_sum_q", 32'(sq1), 32'(e1[1]));
        chk("sb1_cout_q", 32'(cq1), 32'(e1[0]));
      end
    end
    if (rst_n === 1'b1 && ov4 === 1'b1) begin
      if (q4.size() == 0) chk("sb4_unexpected_valid", 32'd1, 32'd0);
      else begin
        e4 = q4.pop_front();
        chk("sb4_sum_q", 32'(sq4), 32'(e4[7:4]));
        chk("sb4_cout_q", 32'(cq4), 32'(e4[3:0]));
      end
    end
  end

  // One clock cycle on both instances. Called at posedge+1; returns at posedge+1.
  task automatic step(input logic ia1, input logic ib1, input logic iv1, input logic ic1,
                      input logic [3:0] ia4, input logic [3:0] ib4, input logic iv4,
                      input logic ic4);
    a1 = ia1; b1 = ib1; v1 = iv1; clr1 = ic1;
    a4 = ia4; b4 = ib4; v4 = iv4; clr4 = ic4;
    if (iv1) q1.push_back({ia1 ^ ib1, ia1 & ib1});
    if (iv4) q4.push_back({ia4 ^ ib4, ia4 & ib4});
    #3;
    chk("comb1_sum", 32'(sum1), 32'(ia1 ^ ib1));
    chk("comb1_cout", 32'(cout1), 32'(ia1 & ib1));
    chk("comb4_sum", 32'(sum4), 32'(ia4 ^ ib4));
    chk("comb4_cout", 32'(cout4), 32'(ia4 & ib4));
    @(posedge clk);
    #1;
    if (iv1) begin hs1 = ia1 ^ ib1; hc1 = ia1 & ib1; end
    if (iv4) begin hs4 = ia4 ^ ib4; hc4 = ia4 & ib4; end
    if (ic1) cnt1_m = '0;
    else if (iv1 && (ia1 & ib1) && cnt1_m != 16'hFFFF) cnt1_m = cnt1_m + 16'd1;
    if (ic4) cnt4_m = '0;
    else if (iv4 && (|(ia4 & ib4)) && cnt4_m != 2'd3) cnt4_m = cnt4_m + 2'd1;
    chk("out_valid1", 32'(ov1), 32'(iv1));
    chk("out_valid4", 32'(ov4), 32'(iv4));
    chk("carry_cnt1", 32'(cnt1), 32'(cnt1_m));
    chk("carry_cnt4", 32'(cnt4), 32'(cnt4_m));
    if (!iv1) begin
      chk("hold1_sum_q", 32'(sq1), 32'(hs1));
      chk("hold1_cout_q", 32'(cq1), 32'(hc1));
    end
    if (!iv4) begin
      chk("hold4_sum_q", 32'(sq4), 32'(hs4));
      chk("hold4_cout_q", 32'(cq4), 32'(hc4));
    end
  endtask

  task automatic chk_zero_regs(input string tag);
    chk({tag, "_sum_q1"}, 32'(sq1), 32'd0);
    chk({tag, "_cout_q1"}, 32'(cq1), 32'd0);
    chk({tag, "_out_valid1"}, 32'(ov1), 32'd0);
    chk({tag, "_carry_cnt1"}, 32'(cnt1), 32'd0);
    chk({tag, "_sum_q4"}, 32'(sq4), 32'd0);
    chk({tag, "_cout_q4"}, 32'(cq4), 32'd0);
    chk({tag, "_out_valid4"}, 32'(ov4), 32'd0);
    chk({tag, "_carry_cnt4"}, 32'(cnt4), 32'd0);
  endtask

  logic [1:0] tt_a[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] tt_b[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       tt_s[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       tt_c[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] sat_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst_n = 1'b0;
    a1 = 0; b1 = 0; v1 = 0; clr1 = 0;
    a4 = '0; b4 = '0; v4 = 0; clr4 = 0;
    hs1 = 0; hc1 = 0; cnt1_m = '0;
    hs4 = '0; hc4 = '0; cnt4_m = '0;
    #2;
    chk_zero_regs("reset");

    // Truth table and 4-lane pattern, combinational outputs live during reset.
    for (int i = 0; i < 4; i++) begin
      a1 = tt_a[i][0]; b1 = tt_b[i][0];
      #10;
      chk("tt_sum", 32'(sum1), 32'(tt_s[i]));
      chk("tt_cout", 32'(cout1), 32'(tt_c[i]));
    end
    a4 = 4'b1100; b4 = 4'b1010;
    #10;
    chk("w4_sum", 32'(sum4), 32'h6);
    chk("w4_cout", 32'(cout4), 32'h8);
    chk_zero_regs("reset_hold");

    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Registered path: capture, then hold with valid dropped.
    step(1, 1, 1, 0, 4'b1100, 4'b1010, 1, 0);
    chk("reg1_sum_q", 32'(sq1), 32'd0);
    chk("reg1_cout_q", 32'(cq1), 32'd1);
    chk("reg4_sum_q", 32'(sq4), 32'h6);
    chk("reg4_cout_q", 32'(cq4), 32'h8);
    step(0, 1, 0, 0, 4'b0101, 4'b0101, 0, 0);
    chk("held1_cout_q", 32'(cq1), 32'd1);
    step(1, 0, 1, 0, 4'b0011, 4'b0110, 1, 0);
    step(0, 1, 1, 0, 4'b1111, 4'b0000, 1, 0);

    // Saturation on the 2-bit counter, then clear beating a carry.
    step(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 4'b0011, 4'b0011, 1, 0);
      chk("sat_cnt4", 32'(cnt4), 32'(sat_exp[i]));
    end
    step(0, 0, 0, 0, 4'b0001, 4'b0001, 1, 1);
    chk("clr_wins_cnt4", 32'(cnt4), 32'd0);

    // Asynchronous reset between edges while results are valid.
    step(1, 1, 1, 0, 4'b1111, 4'b1111, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_regs("async_reset");
    chk("async_comb_sum4", 32'(sum4), 32'h0);
    chk("async_comb_cout4", 32'(cout4), 32'hF);
    q1.delete(); q4.delete();
    hs1 = 0; hc1 = 0; cnt1_m = '0;
    hs4 = '0; hc4 = '0; cnt4_m = '0;
    v1 = 0; v4 = 0; clr1 = 0; clr4 = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
           4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
    end

    step(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    step(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    chk("sb4_drained", 32'(q4.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
